load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the 5-stage pipeline; the initiator side of the data memory's single-port interface. Takes one decoded load/store per cycle from the EX/MEM register, drives word-aligned address/data/write-enable to data memory, and returns sign/zero-extended load data. The memory only writes whole 32-bit words, so byte/halfword stores run a two-cycle read-modify-write and stall the pipeline. Misaligned word/halfword accesses are suppressed and flagged.

## Interface
- MEM_WORDS, 128: memory depth in words; addresses with word index ≥ MEM_WORDS are flagged out-of-range.
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  request present this cycle
- i_op  in  3  operation: LW, LH, LHU, LB, LBU, SW, SH, SB (encodings in package)
- i_addr  in  32  byte address from ALU
- i_wdata  in  32  store data (rt); sub-word stores use low bits
- o_stall  out  1  hold EX/MEM and upstream; request must stay stable while high
- o_rdata  out  32  registered, extended load result
- o_rvalid  out  1  one-cycle pulse, o_rdata valid
- o_fault  out  1  one-cycle pulse: misaligned or out-of-range request dropped
- o_mem_addr  out  32  {i_addr[31:2], 2'b00}
- o_mem_wdata  out  32  word to write
- o_mem_we  out  1  memory write enable
- i_mem_rdata  in  32  combinational memory read word (memory returns 0 while we=1)

## Operation
- Little-endian lanes: byte k (addr[1:0]=k) = bits [8k+7:8k]; halfword at addr[1] = bits [16·addr[1]+15 : 16·addr[1]].
- Alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0. Range: addr[31:2] < MEM_WORDS. Violation → o_mem_we=0, no state change, o_fault pulses next cycle, no o_rvalid.
- FSM states: IDLE, RMW_WR.
- IDLE, valid load: o_mem_we=0; lane selected, LB/LH sign-extend, LBU/LHU zero-extend; result registered to o_rdata, o_rvalid=1 next cycle. o_stall=0.
- IDLE, valid SW: o_mem_we=1, o_mem_wdata=i_wdata, single cycle, o_stall=0.
- IDLE, valid SB/SH: o_mem_we=0 (read phase), o_stall=1; merged word = i_mem_rdata with target lane replaced by i_wdata[7:0]/[15:0], latched into merge register; → RMW_WR.
- RMW_WR: o_mem_we=1, o_mem_wdata=merge register, o_stall=0, → IDLE. Request is still present (held by stall) and not re-decoded.
- i_valid=0 in IDLE: o_mem_we=0, outputs pulse low.
- Store never asserts o_rvalid.

## Timing
- Reset (i_rst=1 at a rising edge): state=IDLE, o_rdata=0, o_rvalid=0, o_fault=0, merge register=0. o_mem_we and o_stall forced 0 combinationally whenever i_rst=1, so reset during RMW_WR suppresses the pending write (store lost, by design).
- Load latency: request at edge N → o_rdata/o_rvalid valid after edge N+1, for one cycle.
- SW: memory written at edge N+1 (same cycle as request).
- SB/SH: read in cycle N, write at end of cycle N+1; o_stall high for exactly one cycle; next request accepted cycle N+2.
- Back-to-back loads: one per cycle, o_rvalid continuous.
- Store followed by load to same word: load sees new data (write at edge precedes next cycle's combinational read).
- o_fault: registered, one cycle after offending request.

## Structure
- Package lsu_pkg: op encodings (LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7), state enum, helper constants for lane widths.
- One sub-module natural: lsu_lane_align — combinational load extract/extend and store lane merge, given op, addr[1:0], word, data. FSM, registers and fault logic stay in top.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10; LW @0x10 → o_rvalid next cycle, o_rdata=0xDEADBEEF, o_stall never high.
- SB 0x55 @0x11 over 0xDEADBEEF → o_stall high 1 cycle, memory word becomes 0xDEAD55EF; LBU @0x11 → 0x00000055.
- LB @0x13 on 0xDEAD55EF → 0xFFFFFFDE; LHU @0x12 → 0x0000DEAD; LH @0x10 → 0x000055EF.
- LW @0x12 and SH @0x11 → o_fault pulse, o_mem_we never 1, memory unchanged, no o_rvalid; LW @ 4·MEM_WORDS → o_fault.
- SH 0x1234 @0x22 with i_rst asserted during RMW_WR → no write, word unchanged, state IDLE, all outputs 0.
- Streams: LW,LW,SW,LW same address every cycle → one result per load, last load returns stored value, no stall.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
//
// Purpose: operation encodings, FSM state type, lane widths and small
// decode helpers used by load_store_unit and lsu_lane_align.
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  function automatic logic is_load(lsu_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Sub-word stores cannot be written directly; they need read-modify-write.
  function automatic logic is_sub_store(lsu_op_e op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_aligned(lsu_op_e op, logic [1:0] addr_lo);
    logic ok;
    case (op)
      OP_LW, OP_SW:         ok = (addr_lo == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = (addr_lo[0] == 1'b0);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - single-port data memory bus
//
// Purpose: groups the word-aligned data memory signals.
// Signals:
//   o_mem_addr   word-aligned byte address (LSU -> memory)
//   o_mem_wdata  write word                (LSU -> memory)
//   o_mem_we     write enable              (LSU -> memory)
//   i_mem_rdata  combinational read word   (memory -> LSU)
// Modports: master = LSU side, slave = memory side.
interface load_store_unit_if;

  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_addr,
    output o_mem_wdata,
    output o_mem_we,
    input  i_mem_rdata
  );

  modport slave (
    input  o_mem_addr,
    input  o_mem_wdata,
    input  o_mem_we,
    output i_mem_rdata
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// rtl/load_store_unit_lane_align.sv - load lane extract/extend and store lane merge
//
// Purpose: purely combinational little-endian lane handling.
// Ports:
//   op_i         decoded operation
//   addr_lo_i    byte offset within the word
//   word_i       word read from memory
//   data_i       store data (sub-word stores use the low bits)
//   load_data_o  selected lane, sign- or zero-extended to 32 bits
//   merged_o     word_i with the store lane replaced by data_i
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]        byte_base;
  logic [4:0]        half_base;
  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  assign byte_base = {addr_lo_i, 3'b000};
  assign half_base = {addr_lo_i[1], 4'b0000};
  assign byte_sel  = word_i[byte_base +: BYTE_W];
  assign half_sel  = word_i[half_base +: HALF_W];

  always_comb begin
    load_data_o = word_i;
    case (op_i)
      OP_LB:   load_data_o = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      OP_LBU:  load_data_o = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      OP_LH:   load_data_o = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      OP_LHU:  load_data_o = {{(WORD_W-HALF_W){1'b0}}, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (op_i)
      OP_SB:   merged_o[byte_base +: BYTE_W] = data_i[BYTE_W-1:0];
      OP_SH:   merged_o[half_base +: HALF_W] = data_i[HALF_W-1:0];
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit
//
// Purpose: drives the data memory for one load/store per cycle, returns
// extended load data one cycle later, runs read-modify-write for sub-word
// stores and drops misaligned or out-of-range requests with a fault pulse.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_valid/i_op/i_addr/i_wdata  request from EX/MEM
//   o_stall              hold the request stable (RMW read phase)
//   o_rdata/o_rvalid     registered load result and its one-cycle strobe
//   o_fault              one-cycle pulse for a dropped request
//   mem                  data memory bus (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  lsu_op_e     i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_fault,
  load_store_unit_if.master mem
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        fault_q, fault_d;
  logic [31:0] merge_q, merge_d;

  logic        mem_we;
  logic        stall;
  logic [31:0] mem_wdata;
  logic        req_ok;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ok = is_aligned(i_op, i_addr[1:0]) && (i_addr[31:2] < WORD_LIMIT);

  lsu_lane_align u_lane_align (
    .op_i        (i_op),
    .addr_lo_i   (i_addr[1:0]),
    .word_i      (mem.i_mem_rdata),
    .data_i      (i_wdata),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      merge_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      merge_q  <= merge_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    fault_d   = 1'b0;
    merge_d   = merge_q;
    mem_we    = 1'b0;
    stall     = 1'b0;
    mem_wdata = i_wdata;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (!req_ok) begin
            fault_d = 1'b1;
          end else if (is_load(i_op)) begin
            rdata_d  = load_data;
            rvalid_d = 1'b1;
          end else if (is_sub_store(i_op)) begin
            // Read phase: the memory read word is merged now and written next cycle.
            stall   = 1'b1;
            merge_d = merged;
            state_d = ST_RMW_WR;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      ST_RMW_WR: begin
        // Request is still held by the stall but is not decoded again.
        mem_we    = 1'b1;
        mem_wdata = merge_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the write immediately, so a pending RMW write is dropped.
  assign mem.o_mem_we    = mem_we && !i_rst;
  assign o_stall         = stall && !i_rst;
  assign mem.o_mem_addr  = {i_addr[31:2], 2'b00};
  assign mem.o_mem_wdata = mem_wdata;

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_fault  = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 128;

  logic        clk;
  logic        rst;
  logic        i_valid;
  lsu_op_e     i_op;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_fault;

  load_store_unit_if mem_bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_stall  (o_stall),
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .o_fault  (o_fault),
    .mem      (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [29:0] bus_idx;
  logic        bus_in_range;

  assign bus_idx      = mem_bus.o_mem_addr[31:2];
  assign bus_in_range = (bus_idx < 30'(MEM_WORDS));
  assign mem_bus.i_mem_rdata = mem_bus.o_mem_we ? 32'h0 :
                               (bus_in_range ? mem[bus_idx[6:0]] : 32'h0);

  always @(posedge clk) begin
    if (mem_bus.o_mem_we && bus_in_range) mem[bus_idx[6:0]] <= mem_bus.o_mem_wdata;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_fault = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_load(lsu_op_e op, logic [1:0] lo, logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (8 * lo);
    h = w >> (16 * lo[1]);
    case (op)
      OP_LB:   return {{24{b[7]}}, b[7:0]};
      OP_LBU:  return {24'h0, b[7:0]};
      OP_LH:   return {{16{h[15]}}, h[15:0]};
      OP_LHU:  return {16'h0, h[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(lsu_op_e op, logic [1:0] lo, logic [31:0] w, logic [31:0] d);
    if (op == OP_SB) return (w & ~(32'hFF << (8 * lo))) | ({24'h0, d[7:0]} << (8 * lo));
    return (w & ~(32'hFFFF << (16 * lo[1]))) | ({16'h0, d[15:0]} << (16 * lo[1]));
  endfunction

  function automatic logic model_ok(lsu_op_e op, logic [31:0] a);
    logic al;
    case (op)
      OP_LW, OP_SW:         al = (a[1:0] == 2'b00);
      OP_LH, OP_LHU, OP_SH: al = (a[0] == 1'b0);
      default:              al = 1'b1;
    endcase
    return al && (a[31:2] < 30'(MEM_WORDS));
  endfunction

  // After each active edge: compare registered outputs against the scoreboard.
  task automatic sample_post();
    logic [31:0] e;
    chk("rvalid", {31'h0, o_rvalid}, {31'h0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdata", o_rdata, e);
    end
    chk("fault", {31'h0, o_fault}, {31'h0, exp_fault});
    exp_fault = 1'b0;
  endtask

  task automatic issue(lsu_op_e op, logic [31:0] addr, logic [31:0] wd);
    logic        ok;
    logic        ld;
    logic        sub;
    logic [6:0]  idx;
    logic [31:0] mw;
    ok  = model_ok(op, addr);
    ld  = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LB) || (op == OP_LBU);
    sub = (op == OP_SB) || (op == OP_SH);
    idx = addr[8:2];
    i_valid = 1'b1;
    i_op    = op;
    i_addr  = addr;
    i_wdata = wd;
    #1;
    chk("stall", {31'h0, o_stall}, {31'h0, ok && sub});
    chk("mem_we", {31'h0, mem_bus.o_mem_we}, {31'h0, ok && (op == OP_SW)});
    chk("mem_addr", mem_bus.o_mem_addr, {addr[31:2], 2'b00});
    if (ok && ld) exp_q.push_back(model_load(op, addr[1:0], ref_mem[idx]));
    if (ok && op == OP_SW) begin
      chk("mem_wdata", mem_bus.o_mem_wdata, wd);
      ref_mem[idx] = wd;
    end
    exp_fault = !ok;
    @(posedge clk);
    #1;
    sample_post();
    if (ok && sub) begin
      mw = model_merge(op, addr[1:0], ref_mem[idx], wd);
      chk("rmw_stall", {31'h0, o_stall}, 32'h0);
      chk("rmw_we", {31'h0, mem_bus.o_mem_we}, 32'h1);
      chk("rmw_wdata", mem_bus.o_mem_wdata, mw);
      ref_mem[idx] = mw;
      @(posedge clk);
      #1;
      sample_post();
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
    #1;
    chk("idle_we", {31'h0, mem_bus.o_mem_we}, 32'h0);
    chk("idle_stall", {31'h0, o_stall}, 32'h0);
    @(posedge clk);
    #1;
    sample_post();
  endtask

  task automatic chk_mem(string tag, int idx);
    chk(tag, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[8]     = 32'hCAFEF00D;
    ref_mem[8] = 32'hCAFEF00D;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_op    = OP_LW;
    i_addr  = 32'h0;
    i_wdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_rvalid", {31'h0, o_rvalid}, 32'h0);
    chk("rst_fault", {31'h0, o_fault}, 32'h0);
    chk("rst_stall", {31'h0, o_stall}, 32'h0);
    chk("rst_we", {31'h0, mem_bus.o_mem_we}, 32'h0);
    rst = 1'b0;
    idle();

    issue(OP_SW, 32'h10, 32'hDEADBEEF);
    chk_mem("sw_word", 4);
    issue(OP_LW, 32'h10, 32'h0);

    issue(OP_SB, 32'h11, 32'h00000055);
    chk("sb_word", mem[4], 32'hDEAD55EF);
    issue(OP_LBU, 32'h11, 32'h0);
    issue(OP_LB,  32'h13, 32'h0);
    issue(OP_LHU, 32'h12, 32'h0);
    issue(OP_LH,  32'h10, 32'h0);
    idle();

    issue(OP_LW, 32'h12, 32'h0);
    issue(OP_SH, 32'h11, 32'h0000ABCD);
    issue(OP_LW, 32'(4 * MEM_WORDS), 32'h0);
    issue(OP_SW, 32'(4 * MEM_WORDS), 32'h12345678);
    idle();
    chk_mem("fault_word", 4);

    // SH with reset landing in the write cycle: the write must be dropped.
    i_valid = 1'b1;
    i_op    = OP_SH;
    i_addr  = 32'h22;
    i_wdata = 32'h00001234;
    #1;
    chk("rst_sh_stall", {31'h0, o_stall}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_rmw_we", {31'h0, mem_bus.o_mem_we}, 32'h0);
    chk("rst_rmw_stall", {31'h0, o_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("post_rst_rdata", o_rdata, 32'h0);
    chk("post_rst_rvalid", {31'h0, o_rvalid}, 32'h0);
    chk("post_rst_fault", {31'h0, o_fault}, 32'h0);
    chk("post_rst_we", {31'h0, mem_bus.o_mem_we}, 32'h0);
    chk("post_rst_word", mem[8], 32'hCAFEF00D);
    idle();
    issue(OP_LHU, 32'h22, 32'h0);

    issue(OP_LW, 32'h40, 32'h0);
    issue(OP_LW, 32'h40, 32'h0);
    issue(OP_SW, 32'h40, 32'hA5A5C3C3);
    issue(OP_LW, 32'h40, 32'h0);
    idle();
    chk_mem("stream_word", 16);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
